// File: rtl/mqs_axi4_pipeline_otl.sv
// mqs_axi4_pipeline_otl
// AXI4 register-slice pipeline with a per-channel stage count and a
// write/read outstanding-burst limiter.
//
// Ports:
//   ACLK, ARESET          clock, synchronous active-high reset
//   mst_AW*/W*/AR*        request channels from the master (READY out)
//   mst_B*/R*             response channels to the master (READY in)
//   slv_AW*/W*/AR*        request channels to the slave (READY in)
//   slv_B*/R*             response channels from the slave (READY out)
//   wr_outstanding        write bursts in flight (AW accepted, B not yet returned)
//   rd_outstanding        read bursts in flight (AR accepted, RLAST not yet returned)
//   protocol_err          sticky: a B or RLAST arrived with nothing outstanding
//   quiesce_req/ack       only when MQS_AXI4_PIPE_QUIESCE_EN is defined
//
// Build option: MQS_AXI4_PIPE_QUIESCE_EN adds the quiesce handshake.

// Two-entry skid slice. in_ready is a flop, so it never depends
// combinationally on out_ready; two entries keep 1 beat/cycle under that.
module mqs_axi4_pipeline_otl_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         empty
);
  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, rd_ptr_q;
  logic [1:0]   cnt_q, cnt_d;
  logic         rdy_q;
  logic         push, pop;

  assign push      = in_valid && rdy_q;
  assign pop       = out_valid && out_ready;
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];
  assign in_ready  = rdy_q;
  assign empty     = (cnt_q == 2'd0);

  always_comb begin
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rdy_q <= (cnt_d != 2'd2);
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Payload storage needs no reset: it is only observed while cnt_q != 0.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end
endmodule

// Chain of STAGES slices; STAGES = 0 is a wire, qualified by live so
// nothing is presented or accepted while in reset.
module mqs_axi4_pipeline_otl_chain #(
  parameter int W      = 8,
  parameter int STAGES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         live,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         empty
);
  if (STAGES == 0) begin : g_pass
    assign out_valid = in_valid & live;
    assign in_ready  = out_ready & live;
    assign out_data  = in_data;
    assign empty     = 1'b1;
  end else begin : g_slices
    logic [STAGES:0]   v;
    logic [STAGES:0]   r;
    logic [W-1:0]      d [STAGES+1];
    logic [STAGES-1:0] e;

    assign v[0]      = in_valid & live;
    assign d[0]      = in_data;
    assign in_ready  = r[0] & live;
    assign r[STAGES] = out_ready;
    assign out_valid = v[STAGES];
    assign out_data  = d[STAGES];
    assign empty     = &e;

    for (genvar i = 0; i < STAGES; i++) begin : g_s
      mqs_axi4_pipeline_otl_slice #(.W(W)) u_slice (
        .clk      (clk),
        .rst      (rst),
        .in_valid (v[i]),
        .in_ready (r[i]),
        .in_data  (d[i]),
        .out_valid(v[i+1]),
        .out_ready(r[i+1]),
        .out_data (d[i+1]),
        .empty    (e[i])
      );
    end
  end
endmodule

module mqs_axi4_pipeline_otl #(
  parameter int ADDR_WIDTH         = 64,
  parameter int DATA_WIDTH         = 64,
  parameter int ID_WIDTH           = 8,
  parameter int USER_WIDTH         = 1,
  parameter int AW_STAGES          = 1,
  parameter int W_STAGES           = 1,
  parameter int B_STAGES           = 1,
  parameter int AR_STAGES          = 1,
  parameter int R_STAGES           = 1,
  parameter int MAX_WR_OUTSTANDING = 8,
  parameter int MAX_RD_OUTSTANDING = 8
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
`ifdef MQS_AXI4_PIPE_QUIESCE_EN
  input  logic                    quiesce_req,
  output logic                    quiesce_ack,
`endif
  input  logic [ID_WIDTH-1:0]     mst_AWID,
  input  logic [ADDR_WIDTH-1:0]   mst_AWADDR,
  input  logic [7:0]              mst_AWLEN,
  input  logic [2:0]              mst_AWSIZE,
  input  logic [1:0]              mst_AWBURST,
  input  logic [1:0]              mst_AWLOCK,
  input  logic [3:0]              mst_AWCACHE,
  input  logic [2:0]              mst_AWPROT,
  input  logic [3:0]              mst_AWQOS,
  input  logic [3:0]              mst_AWREGION,
  input  logic [USER_WIDTH-1:0]   mst_AWUSER,
  input  logic                    mst_AWVALID,
  output logic                    mst_AWREADY,
  input  logic [DATA_WIDTH-1:0]   mst_WDATA,
  input  logic [DATA_WIDTH/8-1:0] mst_WSTRB,
  input  logic                    mst_WLAST,
  input  logic [USER_WIDTH-1:0]   mst_WUSER,
  input  logic                    mst_WVALID,
  output logic                    mst_WREADY,
  output logic [ID_WIDTH-1:0]     mst_BID,
  output logic [1:0]              mst_BRESP,
  output logic [USER_WIDTH-1:0]   mst_BUSER,
  output logic                    mst_BVALID,
  input  logic                    mst_BREADY,
  input  logic [ID_WIDTH-1:0]     mst_ARID,
  input  logic [ADDR_WIDTH-1:0]   mst_ARADDR,
  input  logic [7:0]              mst_ARLEN,
  input  logic [2:0]              mst_ARSIZE,
  input  logic [1:0]              mst_ARBURST,
  input  logic [1:0]              mst_ARLOCK,
  input  logic [3:0]              mst_ARCACHE,
  input  logic [2:0]              mst_ARPROT,
  input  logic [3:0]              mst_ARQOS,
  input  logic [3:0]              mst_ARREGION,
  input  logic [USER_WIDTH-1:0]   mst_ARUSER,
  input  logic                    mst_ARVALID,
  output logic                    mst_ARREADY,
  output logic [ID_WIDTH-1:0]     mst_RID,
  output logic [DATA_WIDTH-1:0]   mst_RDATA,
  output logic [1:0]              mst_RRESP,
  output logic                    mst_RLAST,
  output logic [USER_WIDTH-1:0]   mst_RUSER,
  output logic                    mst_RVALID,
  input  logic                    mst_RREADY,
  output logic [ID_WIDTH-1:0]     slv_AWID,
  output logic [ADDR_WIDTH-1:0]   slv_AWADDR,
  output logic [7:0]              slv_AWLEN,
  output logic [2:0]              slv_AWSIZE,
  output logic [1:0]              slv_AWBURST,
  output logic [1:0]              slv_AWLOCK,
  output logic [3:0]              slv_AWCACHE,
  output logic [2:0]              slv_AWPROT,
  output logic [3:0]              slv_AWQOS,
  output logic [3:0]              slv_AWREGION,
  output logic [USER_WIDTH-1:0]   slv_AWUSER,
  output logic                    slv_AWVALID,
  input  logic                    slv_AWREADY,
  output logic [DATA_WIDTH-1:0]   slv_WDATA,
  output logic [DATA_WIDTH/8-1:0] slv_WSTRB,
  output logic                    slv_WLAST,
  output logic [USER_WIDTH-1:0]   slv_WUSER,
  output logic                    slv_WVALID,
  input  logic                    slv_WREADY,
  input  logic [ID_WIDTH-1:0]     slv_BID,
  input  logic [1:0]              slv_BRESP,
  input  logic [USER_WIDTH-1:0]   slv_BUSER,
  input  logic                    slv_BVALID,
  output logic                    slv_BREADY,
  output logic [ID_WIDTH-1:0]     slv_ARID,
  output logic [ADDR_WIDTH-1:0]   slv_ARADDR,
  output logic [7:0]              slv_ARLEN,
  output logic [2:0]              slv_ARSIZE,
  output logic [1:0]              slv_ARBURST,
  output logic [1:0]              slv_ARLOCK,
  output logic [3:0]              slv_ARCACHE,
  output logic [2:0]              slv_ARPROT,
  output logic [3:0]              slv_ARQOS,
  output logic [3:0]              slv_ARREGION,
  output logic [USER_WIDTH-1:0]   slv_ARUSER,
  output logic                    slv_ARVALID,
  input  logic                    slv_ARREADY,
  input  logic [ID_WIDTH-1:0]     slv_RID,
  input  logic [DATA_WIDTH-1:0]   slv_RDATA,
  input  logic [1:0]              slv_RRESP,
  input  logic                    slv_RLAST,
  input  logic [USER_WIDTH-1:0]   slv_RUSER,
  input  logic                    slv_RVALID,
  output logic                    slv_RREADY,
  output logic [$clog2(MAX_WR_OUTSTANDING+1)-1:0] wr_outstanding,
  output logic [$clog2(MAX_RD_OUTSTANDING+1)-1:0] rd_outstanding,
  output logic                    protocol_err
);
  localparam int AX_W  = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2 + 2 + 4 + 3 + 4 + 4 + USER_WIDTH;
  localparam int W_W   = DATA_WIDTH + DATA_WIDTH/8 + 1 + USER_WIDTH;
  localparam int B_W   = ID_WIDTH + 2 + USER_WIDTH;
  localparam int R_W   = ID_WIDTH + DATA_WIDTH + 2 + 1 + USER_WIDTH;
  localparam int WR_CW = $clog2(MAX_WR_OUTSTANDING+1);
  localparam int RD_CW = $clog2(MAX_RD_OUTSTANDING+1);
  localparam logic [WR_CW-1:0] WR_MAX = WR_CW'(MAX_WR_OUTSTANDING);
  localparam logic [RD_CW-1:0] RD_MAX = RD_CW'(MAX_RD_OUTSTANDING);

  logic             live_q;
  logic             hold_req;
  logic             aw_allow, ar_allow;
  logic             aw_in_ready, ar_in_ready;
  logic             aw_hs, b_hs, ar_hs, rlast_hs;
  logic [WR_CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [RD_CW-1:0] rd_cnt_q, rd_cnt_d;
  logic             wr_err, rd_err, perr_q;
  logic             aw_empty, w_empty, b_empty, ar_empty, r_empty;
  logic             slices_idle;
  logic [AX_W-1:0]  aw_out, ar_out;
  logic [W_W-1:0]   w_out;
  logic [B_W-1:0]   b_out;
  logic [R_W-1:0]   r_out;

  // live_q holds pass-through channels quiet during reset, matching the slices.
  always_ff @(posedge ACLK) begin
    if (ARESET) live_q <= 1'b0;
    else        live_q <= 1'b1;
  end

`ifdef MQS_AXI4_PIPE_QUIESCE_EN
  assign hold_req = quiesce_req;
`else
  assign hold_req = 1'b0;
`endif

  // Gating uses the registered counts so the limit never adds a ready->ready path.
  assign aw_allow    = (wr_cnt_q < WR_MAX) && !hold_req;
  assign ar_allow    = (rd_cnt_q < RD_MAX) && !hold_req;
  assign mst_AWREADY = aw_in_ready && aw_allow;
  assign mst_ARREADY = ar_in_ready && ar_allow;

  mqs_axi4_pipeline_otl_chain #(.W(AX_W), .STAGES(AW_STAGES)) u_aw (
    .clk(ACLK), .rst(ARESET), .live(live_q),
    .in_valid(mst_AWVALID && aw_allow), .in_ready(aw_in_ready),
    .in_data({mst_AWID, mst_AWADDR, mst_AWLEN, mst_AWSIZE, mst_AWBURST, mst_AWLOCK,
              mst_AWCACHE, mst_AWPROT, mst_AWQOS, mst_AWREGION, mst_AWUSER}),
    .out_valid(slv_AWVALID), .out_ready(slv_AWREADY), .out_data(aw_out), .empty(aw_empty)
  );
  assign {slv_AWID, slv_AWADDR, slv_AWLEN, slv_AWSIZE, slv_AWBURST, slv_AWLOCK,
          slv_AWCACHE, slv_AWPROT, slv_AWQOS, slv_AWREGION, slv_AWUSER} = aw_out;

  mqs_axi4_pipeline_otl_chain #(.W(W_W), .STAGES(W_STAGES)) u_w (
    .clk(ACLK), .rst(ARESET), .live(live_q),
    .in_valid(mst_WVALID), .in_ready(mst_WREADY),
    .in_data({mst_WDATA, mst_WSTRB, mst_WLAST, mst_WUSER}),
    .out_valid(slv_WVALID), .out_ready(slv_WREADY), .out_data(w_out), .empty(w_empty)
  );
  assign {slv_WDATA, slv_WSTRB, slv_WLAST, slv_WUSER} = w_out;

  mqs_axi4_pipeline_otl_chain #(.W(B_W), .STAGES(B_STAGES)) u_b (
    .clk(ACLK), .rst(ARESET), .live(live_q),
    .in_valid(slv_BVALID), .in_ready(slv_BREADY),
    .in_data({slv_BID, slv_BRESP, slv_BUSER}),
    .out_valid(mst_BVALID), .out_ready(mst_BREADY), .out_data(b_out), .empty(b_empty)
  );
  assign {mst_BID, mst_BRESP, mst_BUSER} = b_out;

  mqs_axi4_pipeline_otl_chain #(.W(AX_W), .STAGES(AR_STAGES)) u_ar (
    .clk(ACLK), .rst(ARESET), .live(live_q),
    .in_valid(mst_ARVALID && ar_allow), .in_ready(ar_in_ready),
    .in_data({mst_ARID, mst_ARADDR, mst_ARLEN, mst_ARSIZE, mst_ARBURST, mst_ARLOCK,
              mst_ARCACHE, mst_ARPROT, mst_ARQOS, mst_ARREGION, mst_ARUSER}),
    .out_valid(slv_ARVALID), .out_ready(slv_ARREADY), .out_data(ar_out), .empty(ar_empty)
  );
  assign {slv_ARID, slv_ARADDR, slv_ARLEN, slv_ARSIZE, slv_ARBURST, slv_ARLOCK,
          slv_ARCACHE, slv_ARPROT, slv_ARQOS, slv_ARREGION, slv_ARUSER} = ar_out;

  mqs_axi4_pipeline_otl_chain #(.W(R_W), .STAGES(R_STAGES)) u_r (
    .clk(ACLK), .rst(ARESET), .live(live_q),
    .in_valid(slv_RVALID), .in_ready(slv_RREADY),
    .in_data({slv_RID, slv_RDATA, slv_RRESP, slv_RLAST, slv_RUSER}),
    .out_valid(mst_RVALID), .out_ready(mst_RREADY), .out_data(r_out), .empty(r_empty)
  );
  assign {mst_RID, mst_RDATA, mst_RRESP, mst_RLAST, mst_RUSER} = r_out;

  // Bursts are counted at the master side, where they enter and leave the block.
  assign aw_hs    = mst_AWVALID && mst_AWREADY;
  assign b_hs     = mst_BVALID && mst_BREADY;
  assign ar_hs    = mst_ARVALID && mst_ARREADY;
  assign rlast_hs = mst_RVALID && mst_RREADY && mst_RLAST;

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    wr_err   = 1'b0;
    if (aw_hs && !b_hs) begin
      wr_cnt_d = wr_cnt_q + WR_CW'(1);
    end else if (!aw_hs && b_hs) begin
      if (wr_cnt_q == '0) wr_err   = 1'b1;
      else                wr_cnt_d = wr_cnt_q - WR_CW'(1);
    end
  end

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    rd_err   = 1'b0;
    if (ar_hs && !rlast_hs) begin
      rd_cnt_d = rd_cnt_q + RD_CW'(1);
    end else if (!ar_hs && rlast_hs) begin
      if (rd_cnt_q == '0) rd_err   = 1'b1;
      else                rd_cnt_d = rd_cnt_q - RD_CW'(1);
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      perr_q   <= 1'b0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      perr_q   <= perr_q | wr_err | rd_err;
    end
  end

  assign wr_outstanding = wr_cnt_q;
  assign rd_outstanding = rd_cnt_q;
  assign protocol_err   = perr_q;
  assign slices_idle    = aw_empty && w_empty && b_empty && ar_empty && r_empty;

`ifdef MQS_AXI4_PIPE_QUIESCE_EN
  logic ack_q;
  always_ff @(posedge ACLK) begin
    if (ARESET) ack_q <= 1'b0;
    else        ack_q <= quiesce_req && (wr_cnt_q == '0) && (rd_cnt_q == '0) && slices_idle;
  end
  assign quiesce_ack = ack_q;
`else
  // Slice occupancy only matters to the quiesce handshake.
  logic idle_unused;
  assign idle_unused = slices_idle;
`endif
endmodule
